// File: rtl/otp_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : otp_ctrl_pkg                                                 |
// | Description : Shared FSM state encoding and shadow reset value for the     |
// |               boot-time OTP shadow loader.                                 |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package otp_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    READ    = 3'd2,
    CAPTURE = 3'd3,
    CHECK   = 3'd4
  } otp_state_e;

  localparam int unsigned c_shadow_rst = 0;

endpackage

`default_nettype wire

// File: rtl/otp_rd_timer.sv
// +----------------------------------------------------------------------------+
// | Module      : otp_rd_timer                                                 |
// | Description : Holds the OTP read strobe high for RD_CYCLES cycles after a  |
// |               start pulse and flags the final strobe cycle.                |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module otp_rd_timer #(
  parameter int RD_CYCLES = 4
) (
  input  logic xtal_clk,
  input  logic por_rst_n,
  input  logic start,
  output logic rd_en,
  output logic rd_last
);

  localparam int CNT_W = (RD_CYCLES > 1) ? $clog2(RD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(RD_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_rd_en;

  always_ff @(posedge xtal_clk or negedge por_rst_n) begin
    if (!por_rst_n) begin
      r_cnt   <= '0;
      r_rd_en <= 1'b0;
    end else if (start) begin
      r_cnt   <= c_cnt_load;
      r_rd_en <= 1'b1;
    end else if (r_rd_en) begin
      if (r_cnt == '0) begin
        r_rd_en <= 1'b0;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign rd_en   = r_rd_en;
  assign rd_last = r_rd_en && (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/otp_shadow_loader.sv
// +----------------------------------------------------------------------------+
// | Module      : otp_shadow_loader                                            |
// | Description : Boot-time OTP loader: copies NUM_WORDS OTP words into shadow |
// |               registers, verifies an XOR checksum, serves registered reads.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module otp_shadow_loader
  import otp_ctrl_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_WORDS = 32,
  parameter int ADDR_W    = 6,
  parameter int RD_CYCLES = 4
) (
  input  logic              xtal_clk,
  input  logic              por_rst_n,
  input  logic              reload_req,
  output logic [ADDR_W-1:0] otp_addr,
  output logic              otp_rd_en,
  input  logic [DATA_W-1:0] i_otp_q,
  input  logic [ADDR_W-1:0] shadow_rd_addr,
  output logic [DATA_W-1:0] shadow_rd_data,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam logic [ADDR_W-1:0] c_last_addr      = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W:0]   c_num_words      = (ADDR_W + 1)'(NUM_WORDS);
  localparam logic [DATA_W-1:0] c_shadow_rst_val = DATA_W'(c_shadow_rst);

  otp_state_e        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_shadow [NUM_WORDS];

  logic              w_rd_start;
  logic              w_rd_en;
  logic              w_rd_last;
  logic              w_capture;
  logic              w_rd_in_range;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;

  assign w_rd_start    = (r_state == SETUP);
  assign w_capture     = (r_state == CAPTURE);
  assign w_wr_idx      = r_addr[IDX_W-1:0];
  assign w_rd_idx      = shadow_rd_addr[IDX_W-1:0];
  assign w_rd_in_range = ({1'b0, shadow_rd_addr} < c_num_words);

  otp_rd_timer #(
    .RD_CYCLES (RD_CYCLES)
  ) u_rd_timer (
    .xtal_clk  (xtal_clk),
    .por_rst_n (por_rst_n),
    .start     (w_rd_start),
    .rd_en     (w_rd_en),
    .rd_last   (w_rd_last)
  );

  // Reset lands in SETUP with busy set, so the boot load needs no host action.
  always_ff @(posedge xtal_clk or negedge por_rst_n) begin
    if (!por_rst_n) begin
      r_state <= SETUP;
      r_addr  <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        SETUP: r_state <= READ;
        READ: begin
          if (w_rd_last) r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_acc <= r_acc ^ i_otp_q;
          if (r_addr == c_last_addr) begin
            r_state <= CHECK;
          end else begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_state <= SETUP;
          end
        end
        CHECK: begin
          r_err   <= (r_acc != '0);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_addr  <= '0;
          r_state <= IDLE;
        end
        IDLE: begin
          if (reload_req) begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= SETUP;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge xtal_clk or negedge por_rst_n) begin
    if (!por_rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) r_shadow[i] <= c_shadow_rst_val;
    end else if (w_capture) begin
      r_shadow[w_wr_idx] <= i_otp_q;
    end
  end

  // Consumers never see partially reloaded contents: reads are blanked while busy.
  always_ff @(posedge xtal_clk or negedge por_rst_n) begin
    if (!por_rst_n) begin
      r_rd_data <= c_shadow_rst_val;
    end else if (r_busy || !w_rd_in_range) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_shadow[w_rd_idx];
    end
  end

  assign otp_addr       = r_addr;
  assign otp_rd_en      = w_rd_en;
  assign shadow_rd_data = r_rd_data;
  assign load_busy      = r_busy;
  assign load_done      = r_done;
  assign load_err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_otp_shadow_loader.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_otp_shadow_loader                                         |
// | Description : Directed self-checking bench for otp_shadow_loader with a    |
// |               4-word behavioural OTP model.                                |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_otp_shadow_loader;

  localparam int DATA_W    = 8;
  localparam int NUM_WORDS = 4;
  localparam int ADDR_W    = 3;
  localparam int RD_CYCLES = 2;
  localparam int LOAD_CYC  = 17;

  logic              xtal_clk = 1'b0;
  logic              por_rst_n = 1'b0;
  logic              reload_req = 1'b0;
  logic [ADDR_W-1:0] otp_addr;
  logic              otp_rd_en;
  logic [DATA_W-1:0] i_otp_q;
  logic [ADDR_W-1:0] shadow_rd_addr = '0;
  logic [DATA_W-1:0] shadow_rd_data;
  logic              load_busy;
  logic              load_done;
  logic              load_err;

  logic [DATA_W-1:0] mem [4];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 xtal_clk = ~xtal_clk;

  assign i_otp_q = (otp_addr < 3'd4) ? mem[otp_addr[1:0]] : 8'h00;

  otp_shadow_loader #(
    .DATA_W    (DATA_W),
    .NUM_WORDS (NUM_WORDS),
    .ADDR_W    (ADDR_W),
    .RD_CYCLES (RD_CYCLES)
  ) dut (
    .xtal_clk       (xtal_clk),
    .por_rst_n      (por_rst_n),
    .reload_req     (reload_req),
    .otp_addr       (otp_addr),
    .otp_rd_en      (otp_rd_en),
    .i_otp_q        (i_otp_q),
    .shadow_rd_addr (shadow_rd_addr),
    .shadow_rd_data (shadow_rd_data),
    .load_busy      (load_busy),
    .load_done      (load_done),
    .load_err       (load_err)
  );

  task automatic do_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    shadow_rd_addr = a;
    @(negedge xtal_clk);
    d = shadow_rd_data;
  endtask

  task automatic pulse_reload();
    reload_req = 1'b1;
    @(negedge xtal_clk);
    reload_req = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge xtal_clk);
      if (load_done) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    mem = '{8'h11, 8'h22, 8'h44, 8'h77};
    por_rst_n = 1'b0;
    reload_req = 1'b0;
    shadow_rd_addr = '0;
    repeat (2) @(negedge xtal_clk);
    n_cmp++;
    if ({otp_addr, otp_rd_en, load_busy, load_done, load_err} !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_ctrl: got addr=%0d rd_en=%b busy=%b done=%b err=%b, want addr=0 rd_en=0 busy=1 done=0 err=0",
               otp_addr, otp_rd_en, load_busy, load_done, load_err);
    end
    n_cmp++;
    if (shadow_rd_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_rd_data: got %h, want 00", shadow_rd_data);
    end
  endtask

  task automatic test_first_load();
    int run, runs, bad_runs, hi, done_at;
    run = 0; runs = 0; bad_runs = 0; hi = 0; done_at = -1;
    por_rst_n = 1'b1;
    for (int k = 1; k <= LOAD_CYC; k++) begin
      @(negedge xtal_clk);
      if (otp_rd_en) begin
        hi++;
        run++;
      end else if (run != 0) begin
        runs++;
        if (run != RD_CYCLES) bad_runs++;
        run = 0;
      end
      if (load_done && done_at < 0) done_at = k;
      n_cmp++;
      if (shadow_rd_data !== 8'h00) begin
        n_bad++;
        $display("FAIL busy_read cyc=%0d: got %h, want 00", k, shadow_rd_data);
      end
    end
    n_cmp++;
    if (done_at !== LOAD_CYC) begin
      n_bad++;
      $display("FAIL boot_latency: load_done first at cycle %0d, want %0d", done_at, LOAD_CYC);
    end
    n_cmp++;
    if ({load_busy, load_err} !== 2'b00) begin
      n_bad++;
      $display("FAIL boot_status: got busy=%b err=%b, want busy=0 err=0", load_busy, load_err);
    end
    n_cmp++;
    if (runs !== 4 || bad_runs !== 0 || hi !== 8) begin
      n_bad++;
      $display("FAIL rd_en_pulses: got runs=%0d bad_runs=%0d high=%0d, want runs=4 bad_runs=0 high=8",
               runs, bad_runs, hi);
    end
    @(negedge xtal_clk);
    n_cmp++;
    if (shadow_rd_data !== 8'h11) begin
      n_bad++;
      $display("FAIL read_after_done: got %h, want 11", shadow_rd_data);
    end
  endtask

  task automatic test_read_back(input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] e3);
    logic [DATA_W-1:0] exp_v [4];
    logic [DATA_W-1:0] d;
    exp_v = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      do_read(ADDR_W'(i), d);
      n_cmp++;
      if (d !== exp_v[i]) begin
        n_bad++;
        $display("FAIL read_back addr=%0d: got %h, want %h", i, d, exp_v[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [DATA_W-1:0] d;
    do_read(3'd5, d);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++;
      $display("FAIL out_of_range addr=5: got %h, want 00", d);
    end
    do_read(3'd4, d);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++;
      $display("FAIL out_of_range addr=4: got %h, want 00", d);
    end
  endtask

  task automatic test_reload();
    int done_at;
    done_at = -1;
    mem = '{8'h01, 8'h02, 8'h04, 8'h07};
    shadow_rd_addr = '0;
    pulse_reload();
    n_cmp++;
    if ({load_done, load_busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL reload_start: got done=%b busy=%b, want done=0 busy=1", load_done, load_busy);
    end
    for (int k = 1; k <= LOAD_CYC + 3; k++) begin
      @(negedge xtal_clk);
      reload_req = 1'b0;
      if (k == 5 || k == 16) reload_req = 1'b1;
      if (load_done && done_at < 0) done_at = k;
    end
    reload_req = 1'b0;
    n_cmp++;
    if (done_at !== LOAD_CYC) begin
      n_bad++;
      $display("FAIL reload_latency: load_done first at cycle %0d, want %0d", done_at, LOAD_CYC);
    end
    n_cmp++;
    if ({load_done, load_busy, load_err} !== 3'b100) begin
      n_bad++;
      $display("FAIL reload_ignored_pulses: got done=%b busy=%b err=%b, want done=1 busy=0 err=0",
               load_done, load_busy, load_err);
    end
    test_read_back(8'h01, 8'h02, 8'h04, 8'h07);
  endtask

  task automatic test_checksum_err();
    int cyc;
    mem = '{8'h11, 8'h22, 8'h44, 8'h76};
    pulse_reload();
    wait_done(cyc);
    n_cmp++;
    if (cyc < 0) begin
      n_bad++;
      $display("FAIL cksum_done: got no load_done within bound, want load_done=1");
    end
    n_cmp++;
    if (load_err !== 1'b1) begin
      n_bad++;
      $display("FAIL cksum_err: got load_err=%b, want 1", load_err);
    end
    test_read_back(8'h11, 8'h22, 8'h44, 8'h76);
  endtask

  task automatic test_reset_mid_load();
    logic found;
    int done_at;
    found = 1'b0;
    done_at = -1;
    mem = '{8'h11, 8'h22, 8'h44, 8'h77};
    pulse_reload();
    n_cmp++;
    if ({load_done, load_err} !== 2'b00) begin
      n_bad++;
      $display("FAIL reload_clears_err: got done=%b err=%b, want done=0 err=0", load_done, load_err);
    end
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge xtal_clk);
      if (otp_addr == 3'd2 && otp_rd_en) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL word2_read: got no READ on addr 2 within bound, want it");
    end
    por_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({otp_addr, otp_rd_en, load_busy, load_done, load_err, shadow_rd_data} !==
        {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL mid_reset: got addr=%0d rd_en=%b busy=%b done=%b err=%b rd=%h, want 0 0 1 0 0 00",
               otp_addr, otp_rd_en, load_busy, load_done, load_err, shadow_rd_data);
    end
    @(negedge xtal_clk);
    por_rst_n = 1'b1;
    for (int k = 1; k <= LOAD_CYC; k++) begin
      @(negedge xtal_clk);
      if (k == 1) begin
        n_cmp++;
        if ({otp_addr, otp_rd_en} !== {3'd0, 1'b1}) begin
          n_bad++;
          $display("FAIL restart_addr: got addr=%0d rd_en=%b, want addr=0 rd_en=1", otp_addr, otp_rd_en);
        end
      end
      if (load_done && done_at < 0) done_at = k;
    end
    n_cmp++;
    if (done_at !== LOAD_CYC || load_err !== 1'b0) begin
      n_bad++;
      $display("FAIL restart_load: got done at %0d err=%b, want done at %0d err=0", done_at, load_err, LOAD_CYC);
    end
    test_read_back(8'h11, 8'h22, 8'h44, 8'h77);
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_read_back(8'h11, 8'h22, 8'h44, 8'h77);
    test_out_of_range();
    test_reload();
    test_checksum_err();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
